// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin grant, one outstanding bus access,
// timeout abort with error pulse, and registered per-master read data.
//   state | meaning
//   IDLE  | waiting for a request; grant and latch the winner's access
//   BUSY  | access on the bus, waiting for bus_ready or timeout
//   DONE  | one-cycle completion: ack the granted master, flag abort
module dmem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        cpu_stall,
    output logic        bus_en,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            last_grant;
    logic            grant;
    logic            any_req;
    logic            pick_m1;
    logic            tmo;
    logic            finish;
    logic            en_d;
    logic            we_d;
    logic            ack0_d;
    logic            ack1_d;
    logic            err_d;
    logic [31:0]     rdata_d;

    assign any_req = m0_req | m1_req;
    // On a tie the master that did not win last time gets the bus.
    assign pick_m1 = m1_req & (~m0_req | ~last_grant);
    assign tmo     = (cnt == CW'(TIMEOUT - 1));
    assign finish  = bus_ready | tmo;
    assign rdata_d = bus_ready ? bus_rdata : 32'h0000_0000;

    assign cpu_stall = m0_req & ~m0_ack;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (finish)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered bus and handshake outputs.
    always_comb begin
        en_d   = 1'b0;
        we_d   = 1'b0;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        err_d  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    en_d = 1'b1;
                    we_d = pick_m1 ? m1_we : m0_we;
                end
            end
            BUSY: begin
                if (finish) begin
                    ack0_d = ~grant;
                    ack1_d = grant;
                    err_d  = ~bus_ready;
                end else begin
                    en_d = 1'b1;
                    we_d = bus_we;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bus_en     <= 1'b0;
            bus_we     <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            bus_err    <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            m0_rdata   <= 32'h0;
            m1_rdata   <= 32'h0;
            cnt        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            bus_en  <= en_d;
            bus_we  <= we_d;
            m0_ack  <= ack0_d;
            m1_ack  <= ack1_d;
            bus_err <= err_d;
            if (state == IDLE && any_req) begin
                grant      <= pick_m1;
                last_grant <= pick_m1;
                bus_addr   <= pick_m1 ? m1_addr  : m0_addr;
                bus_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
                cnt        <= '0;
            end
            if (state == BUSY) begin
                if (!finish) begin
                    cnt <= cnt + CW'(1);
                end else if (!bus_we) begin
                    if (grant) m1_rdata <= rdata_d;
                    else       m0_rdata <= rdata_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single transactions plus hand-written reset
// and back-to-back sequences; completions are checked against a queue.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, cpu_stall;
    logic        bus_en, bus_we, bus_ready, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    dmem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_b(reset_b),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .cpu_stall(cpu_stall),
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req0, req1, we0, we1;
        logic [31:0] addr, wdata, rdata;
        int          delay;          // BUSY cycles before bus_ready; >= TIMEOUT never
        logic        exp_grant;      // 0 = m0, 1 = m1
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        grant, err;
        logic [31:0] rd0, rd1;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    vec_t        vecs[13];
    logic [31:0] rd_m[2];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] ea, ew;
        logic        ewe;
        int          busy, exp_busy;
        @(negedge clk);
        m0_req = v.req0; m0_we = v.we0; m0_addr = v.addr;          m0_wdata = v.wdata;
        m1_req = v.req1; m1_we = v.we1; m1_addr = v.addr + 32'h40; m1_wdata = ~v.wdata;
        ea  = v.exp_grant ? m1_addr  : m0_addr;
        ew  = v.exp_grant ? m1_wdata : m0_wdata;
        ewe = v.exp_grant ? m1_we    : m0_we;
        if (!ewe) rd_m[v.exp_grant] = v.exp_err ? 32'h0 : v.rdata;
        sb.push_back('{v.exp_grant, v.exp_err, rd_m[0], rd_m[1]});
        exp_busy = v.exp_err ? TIMEOUT : v.delay + 1;
        @(negedge clk);
        chk("bus_en_latency", bus_en, 1'b1);
        busy = 0;
        while (bus_en && busy < 40) begin
            chk("bus_addr", bus_addr, ea);
            chk("bus_wdata", bus_wdata, ew);
            chk("bus_we", bus_we, ewe);
            chk("cpu_stall_busy", cpu_stall, m0_req);
            busy++;
            if (busy == v.delay + 1) begin
                bus_ready = 1'b1;
                bus_rdata = v.rdata;
            end else begin
                bus_ready = 1'b0;
                bus_rdata = $urandom;
            end
            @(negedge clk);
        end
        bus_ready = 1'b0;
        chk("busy_cycles", 32'(busy), 32'(exp_busy));
        chk("cpu_stall_done", cpu_stall, m0_req & v.exp_grant);
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    // Completion monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_b) begin
            if (m0_ack || m1_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("m0_ack", m0_ack, !e.grant);
                    chk("m1_ack", m1_ack, e.grant);
                    chk("bus_err", bus_err, e.err);
                    chk("bus_en_done", bus_en, 1'b0);
                    chk("bus_we_done", bus_we, 1'b0);
                    chk("m0_rdata", m0_rdata, e.rd0);
                    chk("m1_rdata", m1_rdata, e.rd1);
                end
            end else if (bus_err) begin
                chk("stray_bus_err", bus_err, 1'b0);
            end
        end
    end

    initial begin
        //           req0 req1 we0  we1  addr         wdata          rdata          dly grant err
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40,  32'h1111_0000, 32'h1234_5678,  0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h44,  32'h1111_0001, 32'hAAAA_0001,  1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h48,  32'h1111_0002, 32'hAAAA_0002,  0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h4C,  32'h1111_0003, 32'hAAAA_0003,  2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h40,  32'h3501_0FF2, 32'hDEAD_DEAD,  5, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,         32'h1234_5678,  0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h50,  32'h0,         32'h5555_AAAA,  3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h54,  32'h0,         32'h6666_0000,  0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h58,  32'h0,         32'h9999_9999, 99, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h5C,  32'h0,         32'h0BAD_BEEF, 14, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h60,  32'h2222_2222, 32'h0,         99, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h64,  32'h3333_3333, 32'h0,         99, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h68,  32'h4444_4444, 32'h7777_7777,  1, 1'b0, 1'b0};

        reset_b = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        rd_m[0] = 32'h0; rd_m[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_bus_en", bus_en, 1'b0);
        chk("rst_bus_we", bus_we, 1'b0);
        chk("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        reset_b = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset pulse in the middle of an m1 access.
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100;
        @(negedge clk);
        chk("mid_rst_busy", bus_en, 1'b1);
        @(negedge clk);
        #2 reset_b = 1'b0;
        m0_req = 1'b1;
        #1;
        chk("mid_rst_bus_en", bus_en, 1'b0);
        chk("mid_rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        chk("mid_rst_m0_rdata", m0_rdata, 32'h0);
        rd_m[0] = 32'h0; rd_m[1] = 32'h0;
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        reset_b = 1'b1;
        run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h5A5A_A5A5, 1, 1'b0, 1'b0});

        // m0 request held high: BUSY, DONE, IDLE repeating.
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300;
        bus_ready = 1'b1; bus_rdata = 32'h7777_0000;
        rd_m[0] = 32'h7777_0000;
        for (int k = 0; k < 3; k++) sb.push_back('{1'b0, 1'b0, rd_m[0], rd_m[1]});
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("b2b_bus_en", bus_en, (k % 3) == 0);
            chk("b2b_ack", m0_ack, (k % 3) == 1);
            chk("b2b_stall", cpu_stall, (k % 3) != 1);
        end
        m0_req = 1'b0; bus_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum BUSY cycles waiting for bus_ready before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 m0_req / m0_we  input  1 / 1  CPU MEM-stage request, write enable.
REQ-005 m0_addr / m0_wdata  input  32 / 32  CPU address, write data.
REQ-006 m0_rdata / m0_ack  output  32 / 1  CPU read data (registered), one-cycle completion pulse.
REQ-007 m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same widths, directions and meanings as m0, for the secondary (DMA/UART) master.
REQ-008 cpu_stall  output  1  pipeline hold request to the CPU, combinational.
REQ-009 bus_en / bus_we  output  1 / 1  registered slave-side access strobe and write enable.
REQ-010 bus_addr / bus_wdata  output  32 / 32  registered slave-side address and write data.
REQ-011 bus_rdata / bus_ready  input  32 / 1  slave read data; slave completion, valid only while bus_en=1.
REQ-012 bus_err  output  1  one-cycle pulse marking a timed-out transaction.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 IDLE: no request -> stay IDLE; any req=1 -> grant one master, latch its we/addr/wdata into the bus_* registers, clear the timeout counter, go BUSY.
REQ-015 Both requests high in IDLE SHALL be granted to the master not granted last (round-robin); a lone request SHALL be granted regardless of the pointer.
REQ-016 last_grant SHALL update only on entry to BUSY.
REQ-017 BUSY: bus_en=1, bus_we = latched we; bus_addr and bus_wdata SHALL hold stable for the whole state.
REQ-018 BUSY with bus_ready=1 -> DONE; on a read, bus_rdata SHALL be captured into the granted master's rdata register on that edge.
REQ-019 BUSY with bus_ready=0 SHALL increment the counter; when the counter reaches TIMEOUT-1 with bus_ready=0 -> DONE with abort flag set.
REQ-020 An aborted read SHALL load 32'h0000_0000 into the granted master's rdata; writes SHALL never modify rdata.
REQ-021 DONE SHALL last exactly one cycle: granted master's ack=1, bus_en=0, bus_we=0, bus_err = abort flag; all requests ignored; next state IDLE.
REQ-022 A request still high in the IDLE cycle after DONE SHALL be treated as a new transaction.
REQ-023 Minimum latency: request sampled in IDLE at cycle N, bus_ready=1 at N+1 -> ack at N+2.
REQ-024 bus_ready SHALL be ignored in IDLE and DONE.
REQ-025 A master dropping req after grant SHALL NOT abort the transaction; it completes and is acked.
REQ-026 cpu_stall SHALL equal m0_req AND NOT m0_ack.
REQ-027 A master's rdata SHALL hold its value until that master's next read completes.
REQ-028 The timeout counter SHALL be wide enough to hold TIMEOUT-1 without wrap.

Reset
REQ-029 reset_b=0 SHALL immediately force: state IDLE; bus_en, bus_we, m0_ack, m1_ack, bus_err = 0; bus_addr, bus_wdata, m0_rdata, m1_rdata = 0; counter 0; last_grant = m1, so m0 wins the first tie.
REQ-030 Reset asserted mid-BUSY SHALL drop bus_en in the same cycle with no ack issued; the first edge after release samples from IDLE.

Verification
REQ-031 m0 read of addr 0x40, bus_ready=1 on first BUSY cycle with rdata 0x1234_5678 -> bus_en one cycle, m0_ack at N+2, m0_rdata=0x1234_5678, cpu_stall high at N and N+1 only.
REQ-032 m0 and m1 both request out of reset -> m0 served first, m1 granted in the IDLE after m0's DONE; repeated simultaneous requests alternate m0, m1, m0, m1.
REQ-033 m1 write of 0xCAFE_F00D to 0x80, bus_ready delayed 5 cycles -> bus_addr/bus_wdata/bus_we stable for 6 BUSY cycles, m1_ack one pulse, m1_rdata unchanged.
REQ-034 m0 read with bus_ready held 0 -> exactly 15 BUSY cycles, then DONE with m0_ack=1, bus_err=1, m0_rdata=0.
REQ-035 reset_b pulsed low during a BUSY cycle of an m1 access -> bus_en=0 at once, no ack; after release a pending m0 and m1 tie grants m0.
REQ-036 m0_req held high continuously -> back-to-back transactions with one IDLE cycle between each DONE and the next BUSY.
